// File: rtl/stn_tg.sv
// stn_tg - STN panel timing generator / transmitter.
//
// Fetches 1bpp frame bytes over a req/ack read port. Each byte is sent as two
// 4-bit nibbles (high first) on fpdat, qualified by the fpshift clock. Lines
// are closed with an fpline pulse and frames with fpframe.
//
// Ports
//   clk, rst_x        clock, asynchronous active-low reset
//   en                run enable (stop takes effect at the end of a frame)
//   fifo_rdreq/rdack  byte read handshake, fifo_raddr linear byte address
//   fifo_rdata        read data, MSB = leftmost pixel
//   stn_fpframe       frame sync, stn_fpline line latch pulse
//   stn_fpshift       shift clock, stn_fpdat pixel nibble (bit3 = leftmost)
//   underrun          one-cycle pulse when the next byte is late
//   busy              high whenever the generator is not idle
module stn_tg #(
    parameter int H_PIX     = 320,
    parameter int V_LINES   = 160,
    parameter int SHIFT_DIV = 2,
    parameter int HBLANK    = 8,
    parameter int LP_W      = 4
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        en,
    output logic        fifo_rdreq,
    input  logic        fifo_rdack,
    output logic [12:0] fifo_raddr,
    input  logic [7:0]  fifo_rdata,
    output logic        stn_fpframe,
    output logic        stn_fpline,
    output logic        stn_fpshift,
    output logic [3:0]  stn_fpdat,
    output logic        underrun,
    output logic        busy
);

    localparam int BPL     = H_PIX / 8;
    localparam int TOTAL   = BPL * V_LINES;
    localparam int NIB_LEN = 2 * SHIFT_DIV;
    localparam int M1      = (NIB_LEN > HBLANK) ? NIB_LEN : HBLANK;
    localparam int CNT_MAX = (M1 > LP_W) ? M1 : LP_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BYTE_W  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int LINE_W  = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    localparam logic [CNT_W-1:0]  SD_END    = CNT_W'(SHIFT_DIV - 1);
    localparam logic [CNT_W-1:0]  NIB_END   = CNT_W'(NIB_LEN - 1);
    localparam logic [CNT_W-1:0]  HB_END    = CNT_W'(HBLANK - 1);
    localparam logic [CNT_W-1:0]  LP_END    = CNT_W'(LP_W - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BPL - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
    localparam logic [12:0]       ADDR_LAST = 13'(TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, FETCH, NIB_H, NIB_L, STALL, BLANK, LP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BYTE_W-1:0]  byte_cnt;
    logic [LINE_W-1:0]  line_cnt;
    logic [7:0]         data_reg;
    logic [7:0]         pf_reg;
    logic               pf_valid;
    logic               stop_req;

    logic               ack;
    logic               have_byte;
    logic [7:0]         next_byte;
    logic [12:0]        next_addr;

    assign ack       = fifo_rdreq & fifo_rdack;
    // A byte acknowledged in the very cycle it is needed counts as present.
    assign have_byte = pf_valid | ack;
    assign next_byte = pf_valid ? pf_reg : fifo_rdata;
    assign next_addr = (fifo_raddr == ADDR_LAST) ? 13'd0 : fifo_raddr + 13'd1;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state       <= IDLE;
            cnt         <= '0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            data_reg    <= '0;
            pf_reg      <= '0;
            pf_valid    <= 1'b0;
            stop_req    <= 1'b0;
            fifo_rdreq  <= 1'b0;
            fifo_raddr  <= '0;
            stn_fpframe <= 1'b0;
            stn_fpline  <= 1'b0;
            stn_fpshift <= 1'b0;
            stn_fpdat   <= '0;
            underrun    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (!en && state != IDLE) stop_req <= 1'b1;

            // Handshake completion; while streaming the byte lands in the
            // prefetch register (consumers below may override pf_valid).
            if (ack) begin
                fifo_rdreq <= 1'b0;
                if (state inside {NIB_H, NIB_L, BLANK, LP}) begin
                    pf_reg   <= fifo_rdata;
                    pf_valid <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    stop_req <= 1'b0;
                    pf_valid <= 1'b0;
                    if (ack) fifo_raddr <= '0;
                    // A dropped-but-outstanding request must finish first.
                    if (en && !fifo_rdreq) begin
                        state       <= SYNC;
                        cnt         <= '0;
                        stn_fpline  <= 1'b1;
                        stn_fpframe <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                SYNC: begin
                    if (cnt == LP_END) begin
                        state       <= FETCH;
                        cnt         <= '0;
                        stn_fpline  <= 1'b0;
                        stn_fpframe <= 1'b0;
                        fifo_rdreq  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FETCH, STALL: begin
                    if (ack) begin
                        data_reg    <= fifo_rdata;
                        state       <= NIB_H;
                        cnt         <= '0;
                        stn_fpdat   <= fifo_rdata[7:4];
                        stn_fpshift <= 1'b1;
                        if (state == STALL) byte_cnt <= byte_cnt + 1'b1;
                    end
                end

                NIB_H: begin
                    if (cnt == SD_END) stn_fpshift <= 1'b0;
                    if (cnt == NIB_END) begin
                        state       <= NIB_L;
                        cnt         <= '0;
                        stn_fpdat   <= data_reg[3:0];
                        stn_fpshift <= 1'b1;
                        fifo_rdreq  <= 1'b1;
                        fifo_raddr  <= next_addr;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                NIB_L: begin
                    if (cnt == SD_END) stn_fpshift <= 1'b0;
                    if (cnt == NIB_END) begin
                        cnt <= '0;
                        if (byte_cnt == BYTE_LAST) begin
                            state     <= BLANK;
                            byte_cnt  <= '0;
                            stn_fpdat <= '0;
                        end else if (have_byte) begin
                            data_reg    <= next_byte;
                            pf_valid    <= 1'b0;
                            state       <= NIB_H;
                            stn_fpdat   <= next_byte[7:4];
                            stn_fpshift <= 1'b1;
                            byte_cnt    <= byte_cnt + 1'b1;
                        end else begin
                            state    <= STALL;
                            underrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BLANK: begin
                    if (cnt == HB_END) begin
                        state       <= LP;
                        cnt         <= '0;
                        stn_fpline  <= 1'b1;
                        stn_fpframe <= (line_cnt == LINE_LAST);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LP: begin
                    if (cnt == LP_END) begin
                        cnt         <= '0;
                        stn_fpline  <= 1'b0;
                        stn_fpframe <= 1'b0;
                        line_cnt    <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
                        if ((stop_req || !en) && line_cnt == LINE_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            pf_valid <= 1'b0;
                            if (!fifo_rdreq || ack) fifo_raddr <= '0;
                        end else if (have_byte) begin
                            data_reg    <= next_byte;
                            pf_valid    <= 1'b0;
                            state       <= NIB_H;
                            stn_fpdat   <= next_byte[7:4];
                            stn_fpshift <= 1'b1;
                        end else begin
                            // The prefetch request is still outstanding.
                            state <= FETCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stn_tg.sv
module tb_stn_tg;

    localparam int H_PIX   = 16;
    localparam int V_LINES = 2;
    localparam int SD      = 2;
    localparam int HB      = 8;
    localparam int LPW     = 4;
    localparam int BPL     = H_PIX / 8;
    localparam int TOTAL   = BPL * V_LINES;

    logic        clk;
    logic        rst_x;
    logic        en;
    logic        fifo_rdreq;
    logic        fifo_rdack;
    logic [12:0] fifo_raddr;
    logic [7:0]  fifo_rdata;
    logic        stn_fpframe;
    logic        stn_fpline;
    logic        stn_fpshift;
    logic [3:0]  stn_fpdat;
    logic        underrun;
    logic        busy;

    stn_tg #(
        .H_PIX(H_PIX), .V_LINES(V_LINES), .SHIFT_DIV(SD), .HBLANK(HB), .LP_W(LPW)
    ) dut (
        .clk(clk), .rst_x(rst_x), .en(en),
        .fifo_rdreq(fifo_rdreq), .fifo_rdack(fifo_rdack),
        .fifo_raddr(fifo_raddr), .fifo_rdata(fifo_rdata),
        .stn_fpframe(stn_fpframe), .stn_fpline(stn_fpline),
        .stn_fpshift(stn_fpshift), .stn_fpdat(stn_fpdat),
        .underrun(underrun), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame memory and read-port responder
    logic [7:0] ram [TOTAL];
    int dly_mode = 0;
    int addr_q[$];

    function automatic int pick_delay(input logic [12:0] a);
        if (dly_mode == 2) return (a == 13'd1) ? 10 : (a == 13'd2) ? 20 : 1;
        if (dly_mode == 1) return int'($urandom_range(3, 1));
        return 1;
    endfunction

    initial begin
        int rcnt;
        int rdly;
        rcnt = 0;
        rdly = 1;
        fifo_rdack = 1'b0;
        fifo_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_x || fifo_rdack) begin
                fifo_rdack = 1'b0;
                rcnt = 0;
            end else if (fifo_rdreq) begin
                if (rcnt == 0) rdly = pick_delay(fifo_raddr);
                if (rcnt == rdly) begin
                    fifo_rdack = 1'b1;
                    fifo_rdata = ram[int'(fifo_raddr) % TOTAL];
                    addr_q.push_back(int'(fifo_raddr));
                end else begin
                    rcnt++;
                end
            end
        end
    end

    // Panel-side observer
    int nib_q[$];
    int ev_pulses[$], ev_gap[$], ev_frame[$], ev_width[$];
    int stall_q[$];
    int shift_cnt, low_cnt, line_w, line_falls;
    int overlap_cnt, frame_bad, und_high, und_pulses, stall_bad;

    task automatic clear_mon();
        nib_q.delete(); ev_pulses.delete(); ev_gap.delete();
        ev_frame.delete(); ev_width.delete(); stall_q.delete(); addr_q.delete();
        shift_cnt = 0; low_cnt = 0; line_w = 0; line_falls = 0;
        overlap_cnt = 0; frame_bad = 0; und_high = 0; und_pulses = 0; stall_bad = 0;
    endtask

    initial begin
        logic p_shift, p_line, p_und, in_stall;
        logic [3:0] held;
        p_shift = 0; p_line = 0; p_und = 0; in_stall = 0; held = '0;
        forever begin
            @(negedge clk);
            if (stn_fpshift && !p_shift) begin
                shift_cnt++;
                in_stall = 1'b0;
            end
            if (!stn_fpshift && p_shift) nib_q.push_back(int'(stn_fpdat));
            if (stn_fpline && !p_line) begin
                ev_pulses.push_back(shift_cnt);
                ev_gap.push_back(low_cnt);
                ev_frame.push_back(int'(stn_fpframe));
                shift_cnt = 0;
                line_w = 0;
            end
            if (stn_fpline) line_w++;
            if (!stn_fpline && p_line) begin
                ev_width.push_back(line_w);
                line_falls++;
            end
            if (stn_fpshift) low_cnt = 0; else low_cnt++;
            if (stn_fpline && stn_fpshift) overlap_cnt++;
            if (stn_fpframe && !stn_fpline) frame_bad++;
            if (underrun) und_high++;
            if (underrun && !p_und) begin
                und_pulses++;
                stall_q.push_back(int'(stn_fpdat));
                held = stn_fpdat;
                in_stall = 1'b1;
            end else if (in_stall && !stn_fpshift && stn_fpdat != held) begin
                stall_bad++;
            end
            p_shift = stn_fpshift;
            p_line  = stn_fpline;
            p_und   = underrun;
        end
    end

    function automatic int outs();
        return int'({stn_fpframe, stn_fpline, stn_fpshift, stn_fpdat,
                     underrun, busy, fifo_rdreq, fifo_raddr});
    endfunction

    task automatic wait_falls(input int n, input int limit);
        int k = 0;
        while (line_falls < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        chk("reach_lines", (line_falls >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(posedge clk);
            k++;
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_outs", outs(), 0);
    endtask

    // Run `frames` frames from idle, dropping en in line 0 of the last frame.
    task automatic run_frames(input int frames);
        clear_mon();
        @(posedge clk);
        en = 1'b1;
        wait_falls(1 + (frames - 1) * V_LINES, 5000);
        repeat (5) @(posedge clk);
        en = 1'b0;
        wait_idle(5000);
    endtask

    // Reference: the panel sees every byte of every frame in address order,
    // one fpline per line with fpframe only after the last line.
    task automatic check_run(input string nm, input int frames, input int exp_und);
        int n_nib, n_ev, n_addr, a;
        n_nib  = frames * TOTAL * 2;
        n_ev   = 1 + frames * V_LINES;
        n_addr = frames * TOTAL + 1;
        chk({nm, "_nib_cnt"}, nib_q.size(), n_nib);
        for (int i = 0; i < nib_q.size() && i < n_nib; i++) begin
            a = (i / 2) % TOTAL;
            chk({nm, "_nib"}, nib_q[i], (i % 2 == 0) ? int'(ram[a] >> 4) : int'(ram[a] & 8'h0F));
        end
        chk({nm, "_ev_cnt"}, ev_pulses.size(), n_ev);
        for (int i = 0; i < ev_pulses.size() && i < n_ev; i++) begin
            chk({nm, "_pulses"}, ev_pulses[i], (i == 0) ? 0 : 2 * BPL);
            chk({nm, "_frame"}, ev_frame[i], (i == 0 || ((i - 1) % V_LINES) == V_LINES - 1) ? 1 : 0);
            chk({nm, "_lp_w"}, ev_width[i], LPW);
            if (i > 0) chk({nm, "_gap"}, ev_gap[i], SD + HB);
        end
        chk({nm, "_addr_cnt"}, addr_q.size(), n_addr);
        for (int i = 0; i < addr_q.size() && i < n_addr; i++)
            chk({nm, "_addr"}, addr_q[i], i % TOTAL);
        chk({nm, "_underrun"}, und_pulses, exp_und);
        chk({nm, "_und_w"}, und_high, exp_und);
        chk({nm, "_overlap"}, overlap_cnt, 0);
        chk({nm, "_frame_x"}, frame_bad, 0);
    endtask

    task automatic load_fixed();
        ram[0] = 8'hA5; ram[1] = 8'h3C; ram[2] = 8'h0F; ram[3] = 8'hF0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_x = 1'b0;
        en    = 1'b0;
        load_fixed();
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        rst_x = 1'b1;

        // Idle with en low
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_hold", outs(), 0);
        end

        // Known pattern, one frame, en dropped mid line 0
        dly_mode = 0;
        run_frames(1);
        check_run("fix", 1, 0);

        // Restart without reset, random data and ack latency, three frames
        for (int i = 0; i < TOTAL; i++) ram[i] = 8'($urandom);
        dly_mode = 1;
        run_frames(3);
        check_run("rnd", 3, 0);

        // Late byte: stall after the first byte, long wait across a line end
        load_fixed();
        dly_mode = 2;
        run_frames(1);
        check_run("stall", 1, 1);
        chk("stall_cnt", stall_q.size(), 1);
        if (stall_q.size() > 0) chk("stall_nib", stall_q[0], int'(ram[0] & 8'h0F));
        chk("stall_hold", stall_bad, 0);

        // Asynchronous reset in the middle of a nibble
        dly_mode = 1;
        for (int i = 0; i < TOTAL; i++) ram[i] = 8'($urandom);
        @(posedge clk);
        en = 1'b1;
        k = 0;
        while (!stn_fpshift && k < 1000) begin
            @(posedge clk);
            k++;
        end
        chk("reach_shift", int'(stn_fpshift), 1);
        @(posedge clk);
        #2;
        rst_x = 1'b0;
        #1;
        chk("async_rst", outs(), 0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        rst_x = 1'b1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
